// File: rtl/alu_arbiter.sv
// alu_arbiter: serialises two requesters onto one shared combinational ALU
module alu_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_data,
    output logic       rsp0_err,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_data,
    output logic       rsp1_err,
    output logic [7:0] alu_data1,
    output logic [7:0] alu_data2,
    output logic [2:0] alu_select,
    input  logic [7:0] alu_result,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t     state, state_nx;
    logic       last, gnt, win, hs, rsp_rdy;
    logic [2:0] op_r;
    logic [7:0] a_r, b_r, data_r;
    logic       err_r;
    // arbitration, next state and outputs; reset masks the handshake so it always wins
    always_comb begin
        win        = (req0_valid && req1_valid) ? ~last : req1_valid;
        hs         = (state == IDLE) && (req0_valid || req1_valid) && !reset;
        rsp_rdy    = gnt ? rsp1_ready : rsp0_ready;
        state_nx   = (state == IDLE) ? (hs ? ISSUE : IDLE) :
                     (state == ISSUE) ? RESP : (rsp_rdy ? IDLE : RESP);
        req0_ready = hs && !win;
        req1_ready = hs && win;
        rsp0_valid = (state == RESP) && !gnt;
        rsp1_valid = (state == RESP) && gnt;
        rsp0_data  = rsp0_valid ? data_r : 8'h00;
        rsp1_data  = rsp1_valid ? data_r : 8'h00;
        rsp0_err   = rsp0_valid && err_r;
        rsp1_err   = rsp1_valid && err_r;
        alu_select = op_r[2] ? 3'b000 : op_r;
        alu_data1  = a_r;
        alu_data2  = b_r;
        busy       = state != IDLE;
    end
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    // operand latch on handshake, result capture at end of ISSUE, fairness update on completion
    always_ff @(posedge clk) begin
        if (reset) begin
            last   <= 1'b1;
            gnt    <= 1'b0;
            op_r   <= 3'b000;
            a_r    <= 8'h00;
            b_r    <= 8'h00;
            data_r <= 8'h00;
            err_r  <= 1'b0;
        end else begin
            if (hs) begin
                gnt  <= win;
                op_r <= win ? req1_op : req0_op;
                a_r  <= win ? req1_a : req0_a;
                b_r  <= win ? req1_b : req0_b;
            end
            if (state == ISSUE) begin
                data_r <= op_r[2] ? 8'h00 : alu_result;
                err_r  <= op_r[2];
            end
            if (state == RESP && rsp_rdy) last <= gnt;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, backpressure, illegal ops and reset
module tb_alu_arbiter;
    logic       clk = 1'b0, reset;
    logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
    logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
    logic [2:0] req0_op, req1_op, alu_select;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
    logic [7:0] alu_data1, alu_data2, alu_result;
    logic       busy;
    int         total = 0, bad = 0;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select), .alu_result(alu_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // reference ALU: FORWARD passes DATA2
    always_comb
        alu_result = alu_select == 3'd0 ? alu_data2 :
                     alu_select == 3'd1 ? alu_data1 + alu_data2 :
                     alu_select == 3'd2 ? alu_data1 & alu_data2 :
                     alu_select == 3'd3 ? alu_data1 | alu_data2 : 8'h00;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit r, input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        if (r) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // one transaction from a lone requester with response ready held high
    task automatic txn(input bit r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_d, input logic exp_e, input logic [2:0] exp_sel);
        set_req(r, 1'b1, op, a, b);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        chk("hs_ready", r ? req1_ready : req0_ready, 8'd1);
        chk("hs_other_ready", r ? req0_ready : req1_ready, 8'd0);
        chk("hs_busy", busy, 8'd0);
        tick();
        set_req(r, 1'b0, op, a, b);
        #1;
        chk("issue_busy", busy, 8'd1);
        chk("issue_no_rsp", r ? rsp1_valid : rsp0_valid, 8'd0);
        chk("issue_sel", alu_select, exp_sel);
        tick();
        chk("rsp_valid", r ? rsp1_valid : rsp0_valid, 8'd1);
        chk("rsp_other_valid", r ? rsp0_valid : rsp1_valid, 8'd0);
        chk("rsp_data", r ? rsp1_data : rsp0_data, exp_d);
        chk("rsp_err", r ? rsp1_err : rsp0_err, exp_e);
        chk("rsp_busy", busy, 8'd1);
        tick();
        chk("done_busy", busy, 8'd0);
        chk("done_valid", r ? rsp1_valid : rsp0_valid, 8'd0);
    endtask

    initial begin
        int n0, n1;
        bit e;
        logic [7:0] exp_d;
        reset = 1'b1;
        set_req(0, 1'b1, 3'd1, 8'h00, 8'h00);
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready0", req0_ready, 8'd0);
        chk("rst_ready1", req1_ready, 8'd0);
        chk("rst_busy", busy, 8'd0);
        chk("rst_rsp0_valid", rsp0_valid, 8'd0);
        chk("rst_rsp1_valid", rsp1_valid, 8'd0);
        chk("rst_rsp0_data", rsp0_data, 8'h00);
        chk("rst_rsp0_err", rsp0_err, 8'd0);
        chk("rst_sel", alu_select, 8'd0);
        chk("rst_data1", alu_data1, 8'h00);
        req0_valid = 1'b0;
        reset = 1'b0;
        tick();
        // add, then wrap/or/and/illegal on requester 1
        txn(0, 3'b001, 8'h3C, 8'h05, 8'h41, 1'b0, 3'b001);
        txn(1, 3'b001, 8'hFF, 8'h01, 8'h00, 1'b0, 3'b001);
        txn(1, 3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 3'b011);
        txn(1, 3'b010, 8'hF0, 8'h0F, 8'h00, 1'b0, 3'b010);
        txn(1, 3'b110, 8'h12, 8'h34, 8'h00, 1'b1, 3'b000);
        // fairness: both valid straight out of reset, four ops each
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n0 = 0;
        n1 = 0;
        set_req(0, 1'b1, 3'b001, 8'h10, 8'h01);
        set_req(1, 1'b1, 3'b011, 8'h00, 8'h01);
        for (int k = 0; k < 8; k++) begin
            e = k[0];
            #1;
            chk("alt_ready0", req0_ready, {7'd0, !e});
            chk("alt_ready1", req1_ready, {7'd0, e});
            tick();
            if (e) begin
                exp_d = {n1[3:0], 4'h0} | 8'h01;
                n1++;
                set_req(1, n1 < 4, 3'b011, {n1[3:0], 4'h0}, 8'h01);
            end else begin
                exp_d = 8'h10 + n0[7:0] + 8'h01;
                n0++;
                set_req(0, n0 < 4, 3'b001, 8'h10 + n0[7:0], 8'h01);
            end
            tick();
            #1;
            chk("alt_valid", e ? rsp1_valid : rsp0_valid, 8'd1);
            chk("alt_data", e ? rsp1_data : rsp0_data, exp_d);
            tick();
        end
        #1;
        chk("alt_drained0", req0_ready, 8'd0);
        chk("alt_drained1", req1_ready, 8'd0);
        // backpressure: forward A5 held for 10 cycles while requester 1 waits
        rsp0_ready = 1'b0;
        set_req(0, 1'b1, 3'b000, 8'h11, 8'hA5);
        set_req(1, 1'b1, 3'b010, 8'h3C, 8'h0F);
        #1;
        chk("bp_ready0", req0_ready, 8'd1);
        chk("bp_ready1", req1_ready, 8'd0);
        tick();
        req0_valid = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", rsp0_valid, 8'd1);
            chk("bp_data", rsp0_data, 8'hA5);
            chk("bp_err", rsp0_err, 8'd0);
            chk("bp_ready1_low", req1_ready, 8'd0);
            tick();
        end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        chk("bp_release_valid", rsp0_valid, 8'd1);
        tick();
        chk("bp_next_ready1", req1_ready, 8'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("bp_next_data", rsp1_data, 8'h0C);
        tick();
        // reset during ISSUE aborts the transaction
        set_req(0, 1'b1, 3'b001, 8'h01, 8'h02);
        #1;
        chk("ab_ready", req0_ready, 8'd1);
        tick();
        req0_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("ab_busy", busy, 8'd0);
        chk("ab_sel", alu_select, 8'd0);
        chk("ab_data1", alu_data1, 8'h00);
        chk("ab_rsp0_data", rsp0_data, 8'h00);
        for (int k = 0; k < 3; k++) begin
            chk("ab_no_rsp", rsp0_valid, 8'd0);
            tick();
        end
        txn(0, 3'b001, 8'h22, 8'h11, 8'h33, 1'b0, 3'b001);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
